// File: rtl/cgra_lane_adder.sv
// Lane-parallel unsigned adder array: LANES independent WIDTH-bit adds per cycle,
// two-stage pipeline (operand capture, then sum/carry capture) with a valid shift register.
module cgra_lane_adder #(
    parameter int unsigned LANES = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic [LANES*WIDTH-1:0] sum_out,
    output logic [LANES-1:0]       carry_out,
    output logic                   out_valid
);

    localparam int unsigned VW = LANES * WIDTH;

    logic [VW-1:0]    a_q, a_d;
    logic [VW-1:0]    b_q, b_d;
    logic [VW-1:0]    sum_q, sum_d;
    logic [LANES-1:0] carry_q, carry_d;
    logic [1:0]       vld_q, vld_d;

    // Next-state: capture operands, add stage-1 values lane by lane, shift in valid.
    always_comb begin
        a_d     = in_a;
        b_d     = in_b;
        sum_d   = '0;
        carry_d = '0;
        vld_d   = {vld_q[0], 1'b1};
        for (int unsigned i = 0; i < LANES; i++) begin
            {carry_d[i], sum_d[i*WIDTH +: WIDTH]} =
                {1'b0, a_q[i*WIDTH +: WIDTH]} + {1'b0, b_q[i*WIDTH +: WIDTH]};
        end
    end

    // Reset clears both stages so in-flight operands never reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            vld_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign out_valid = vld_q[1];

endmodule

// File: tb/tb_cgra_lane_adder.sv
// Directed and randomized checks of cgra_lane_adder: reset, lane sums, carries, latency, mid-stream reset.
module tb_cgra_lane_adder;

    localparam int unsigned LANES = 32;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned VW    = LANES * WIDTH;
    localparam int unsigned NRND  = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic [VW-1:0]    in_a, in_b;
    logic [VW-1:0]    sum_out;
    logic [LANES-1:0] carry_out;
    logic             out_valid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [VW-1:0] hist_a [NRND];
    logic [VW-1:0] hist_b [NRND];

    cgra_lane_adder #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] lane(input logic [VW-1:0] v, input int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    // Compare every lane against the unsigned sum of the given operand vectors.
    task automatic check_model(input string tag, input logic [VW-1:0] ea,
                               input logic [VW-1:0] eb, input logic ev);
        logic [WIDTH:0]   s;
        logic [LANES-1:0] ec;
        ec = '0;
        for (int i = 0; i < LANES; i++) begin
            s     = {1'b0, lane(ea, i)} + {1'b0, lane(eb, i)};
            ec[i] = s[WIDTH];
            check($sformatf("%s_sum_l%0d", tag, i), 64'(lane(sum_out, i)), 64'(s[WIDTH-1:0]));
        end
        check({tag, "_carry"}, 64'(carry_out), 64'(ec));
        check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s_sum_l%0d", tag, i), 64'(lane(sum_out, i)), 64'h0);
        check({tag, "_carry"}, 64'(carry_out), 64'h0);
        check({tag, "_valid"}, 64'(out_valid), 64'h0);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < LANES; i++) begin
            in_a[i*WIDTH +: WIDTH] = $urandom;
            in_b[i*WIDTH +: WIDTH] = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        randomize_inputs();

        // Reset held for two edges with random operands.
        @(negedge clk);
        randomize_inputs();
        @(negedge clk);
        check_zero("reset");

        // Lane i: A=i, B=32-i -> 32 in every lane.
        reset = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*WIDTH +: WIDTH] = WIDTH'(i);
            in_b[i*WIDTH +: WIDTH] = WIDTH'(32 - i);
        end
        @(negedge clk);
        check("rel1_valid", 64'(out_valid), 64'h0);
        check("rel1_sum_l0", 64'(lane(sum_out, 0)), 64'h0);
        @(negedge clk);
        for (int i = 0; i < LANES; i++)
            check($sformatf("sum32_l%0d", i), 64'(lane(sum_out, i)), 64'd32);
        check("sum32_carry", 64'(carry_out), 64'h0);
        check("rel2_valid", 64'(out_valid), 64'h1);

        // Overflow corners on lanes 0 and 31; latency is two edges.
        in_a[0 +: WIDTH]          = 32'hFFFF_FFFF;
        in_b[0 +: WIDTH]          = 32'h0000_0001;
        in_a[31*WIDTH +: WIDTH]   = 32'hFFFF_FFFF;
        in_b[31*WIDTH +: WIDTH]   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("lat_l0_old", 64'(lane(sum_out, 0)), 64'd32);
        check("lat_carry_old", 64'(carry_out), 64'h0);
        @(negedge clk);
        check("ovf_l0_sum", 64'(lane(sum_out, 0)), 64'h0);
        check("ovf_l31_sum", 64'(lane(sum_out, 31)), 64'hFFFF_FFFE);
        check("ovf_l1_sum", 64'(lane(sum_out, 1)), 64'd32);
        check("ovf_l30_sum", 64'(lane(sum_out, 30)), 64'd32);
        check("ovf_carry", 64'(carry_out), 64'h8000_0001);
        check("ovf_valid", 64'(out_valid), 64'h1);

        // New random operands every cycle; each result appears two edges later.
        for (int t = 0; t < int'(NRND) + 2; t++) begin
            if (t >= 2) check_model($sformatf("rnd%0d", t - 2), hist_a[t-2], hist_b[t-2], 1'b1);
            if (t < int'(NRND)) begin
                randomize_inputs();
                hist_a[t] = in_a;
                hist_b[t] = in_b;
            end
            @(negedge clk);
        end

        // One-cycle reset mid-stream with live operands that must be discarded.
        reset = 1'b1;
        randomize_inputs();
        @(negedge clk);
        check_zero("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*WIDTH +: WIDTH] = 32'hF000_0000 + WIDTH'(i);
            in_b[i*WIDTH +: WIDTH] = 32'h2000_0000;
        end
        @(negedge clk);
        check_zero("post_rst1");
        @(negedge clk);
        for (int i = 0; i < LANES; i++)
            check($sformatf("post_rst2_sum_l%0d", i), 64'(lane(sum_out, i)),
                  64'h1000_0000 + 64'(i));
        check("post_rst2_carry", 64'(carry_out), 64'hFFFF_FFFF);
        check("post_rst2_valid", 64'(out_valid), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
